// File: rtl/float_accumulate_ctrl.sv
// Streaming fp32 accumulator sharing one adder; LEN operands per sum.
// Define FLOAT_ACC_SKIP_ZERO_EN to let +/-0.0 operands bypass the adder.
module float_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] x, z;
  logic [7:0]  ex, ez, d;
  logic [23:0] mx, mz;
  logic [26:0] fz, mask, n;
  logic [27:0] s;
  logic [24:0] rm;
  logic [9:0]  e;
  logic        sub, up;

  always_comb begin
    x    = (b[30:0] > a[30:0]) ? b : a;
    z    = (b[30:0] > a[30:0]) ? a : b;
    ex   = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ez   = (z[30:23] == 8'd0) ? 8'd1 : z[30:23];
    mx   = {|x[30:23], x[22:0]};
    mz   = {|z[30:23], z[22:0]};
    d    = ex - ez;
    sub  = x[31] ^ z[31];
    mask = '0;
    // three guard bits; everything shifted past them folds into sticky
    if (d > 8'd26) begin
      fz = {26'd0, |mz};
    end else begin
      mask = (27'd1 << d) - 27'd1;
      fz   = ({mz, 3'b000} >> d)
           | {26'd0, |({mz, 3'b000} & mask)};
    end
    s = sub ? {1'b0, mx, 3'b000} - {1'b0, fz}
            : {1'b0, mx, 3'b000} + {1'b0, fz};
    e = {2'b00, ex};
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      n = s[26:0];
    end
    for (int i = 0; i < 26; i++) begin
      if (!n[26] && e > 10'd1) begin
        n = n << 1;
        e = e - 10'd1;
      end
    end
    up = n[2] & (n[1] | n[0] | n[3]);
    rm = {1'b0, n[26:3]} + {24'd0, up};
    if (rm[24]) begin
      rm = {1'b0, rm[24:1]};
      e  = e + 10'd1;
    end
    y = {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
    if (e >= 10'd255) y = {x[31], 8'hff, 23'd0};
    if (s == 28'd0) y = {x[31] & z[31], 31'd0};
    // any NaN or Inf operand ends up in x, the larger magnitude
    if (x[30:23] == 8'hff)
      y = (x[22:0] != 23'd0 || (z[30:23] == 8'hff && sub))
          ? 32'h7fc00000 : x;
  end
endmodule

module float_accumulate_ctrl #(
  parameter int XLEN    = 32,
  parameter int LEN     = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_data,
  output logic                     busy,
  output logic [$clog2(LEN+1)-1:0] count
);
  localparam int CW = $clog2(LEN+1);
  localparam int TW = $clog2(ADD_LAT+1);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

  state_t          state, nxt;
  logic [XLEN-1:0] acc, opb, sum;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cnt_inc;
  logic            accept, skip, last;

  assign accept  = (state == LOAD) && in_valid;
  assign cnt_inc = count + CW'(1);
  assign last    = (cnt_inc == CW'(LEN));
`ifdef FLOAT_ACC_SKIP_ZERO_EN
  assign skip = accept && (in_data[30:0] == 31'd0);
`else
  assign skip = 1'b0;
`endif

  float_add u_add (
    .a(acc),
    .b(opb),
    .y(sum)
  );

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid)
          nxt = skip ? (last ? DONE : LOAD) : ADD;
      end
      ADD: if (timer == '0) nxt = last ? DONE : LOAD;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      opb   <= '0;
      count <= '0;
      timer <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        acc   <= '0;
        count <= '0;
      end
      if (accept && !skip) begin
        opb   <= in_data;
        timer <= TW'(ADD_LAT - 1);
      end
      if (skip) count <= cnt_inc;
      if (state == ADD) begin
        if (timer == '0) begin
          acc   <= sum;
          count <= cnt_inc;
        end else begin
          timer <= timer - TW'(1);
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign out_data = acc;
endmodule
